// File: rtl/final_layer_argmax.sv
// Output classifier stage: registers the class scores, then registers the
// index of the largest one. Two register stages, one result per cycle.
// Ties resolve to the lowest index (strict greater-than scan from 0 upward).
module final_layer_argmax #(
  parameter int N_CLASSES = 3,
  parameter int IN_W      = 72,
  parameter int OUT_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] input_vector [0:N_CLASSES-1],
  output logic        [OUT_W-1:0] output_value
);

  logic signed [IN_W-1:0] score_q [0:N_CLASSES-1];
  logic signed [IN_W-1:0] best_val;
  logic        [OUT_W-1:0] best_idx;

  // Stage 1: capture every class score; reset clears them so the scan sees all-zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_CLASSES; i++) score_q[i] <= '0;
    end else begin
      score_q <= input_vector;
    end
  end

  // Linear scan over the captured scores; direct signed compare avoids any
  // subtraction overflow at the extremes, strict '>' keeps the lowest index on ties.
  always_comb begin
    best_val = score_q[0];
    best_idx = '0;
    for (int i = 1; i < N_CLASSES; i++) begin
      if (score_q[i] > best_val) begin
        best_val = score_q[i];
        best_idx = OUT_W'(i);
      end
    end
  end

  // Stage 2: register the winning index; reset forces class 0.
  always_ff @(posedge clk) begin
    if (!rst) output_value <= '0;
    else      output_value <= best_idx;
  end

endmodule

// File: tb/tb_final_layer_argmax.sv
// Self-checking bench for final_layer_argmax: directed cases followed by
// randomized vectors with occasional resets, compared against a reference
// argmax computed from the captured input history.
module tb_final_layer_argmax;
  localparam int N = 3;
  localparam int W = 72;
  localparam int OW = 2;

  typedef logic signed [W-1:0] score_t;

  localparam score_t MOST_NEG = 72'sh800000000000000000;
  localparam score_t MOST_POS = 72'sh7FFFFFFFFFFFFFFFFF;

  logic          clk;
  logic          rst;
  score_t        vec [0:N-1];
  logic [OW-1:0] output_value;

  // reference state: scores captured at the previous edge
  score_t cap [0:N-1];
  int     exp_out;
  int     n_chk;
  int     n_fail;

  final_layer_argmax #(.N_CLASSES(N), .IN_W(W), .OUT_W(OW)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_vector (vec),
    .output_value (output_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // maximum value first, then the first index that holds it
  function automatic int ref_argmax(input score_t s [0:N-1]);
    score_t mx;
    mx = s[0];
    for (int i = 1; i < N; i++) if (s[i] > mx) mx = s[i];
    for (int i = 0; i < N; i++) if (s[i] == mx) return i;
    return 0;
  endfunction

  task automatic set_vec(input score_t a, input score_t b, input score_t c);
    vec[0] = a;
    vec[1] = b;
    vec[2] = c;
  endtask

  // one clock edge with the given reset level, then compare against the model
  task automatic step(input logic r, input string tag);
    rst = r;
    if (!r) begin
      exp_out = 0;
      for (int i = 0; i < N; i++) cap[i] = '0;
    end else begin
      exp_out = ref_argmax(cap);
      cap = vec;
    end
    @(posedge clk);
    #1;
    n_chk++;
    assert (output_value === OW'(exp_out))
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, output_value, exp_out);
    end
  endtask

  function automatic score_t rand_score();
    logic [95:0] raw;
    score_t      v;
    int          mode;
    mode = $urandom_range(0, 3);
    raw  = {$urandom, $urandom, $urandom};
    case (mode)
      0:       v = raw[W-1:0];
      1:       v = score_t'($urandom_range(0, 6)) - 3;
      2:       v = ($urandom_range(0, 1) != 0) ? MOST_NEG : MOST_POS;
      default: v = score_t'(signed'(raw[31:0]));
    endcase
    return v;
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    set_vec(0, 0, 0);
    for (int i = 0; i < N; i++) cap[i] = '0;

    // reset held for 5 edges
    for (int k = 0; k < 5; k++) step(1'b0, "reset_hold");

    // release with data present: 0 on the capture edge, 2 afterwards
    set_vec(500, 300000, 2000000);
    step(1'b1, "release_capture");
    step(1'b1, "basic_max2");

    // negatives and signed extremes
    set_vec(-5, -1, -1000);
    step(1'b1, "neg_fill");
    step(1'b1, "neg_max1");
    set_vec(MOST_NEG, 0, MOST_POS);
    step(1'b1, "ext_fill");
    step(1'b1, "extremes_max2");
    set_vec(MOST_POS, MOST_NEG, MOST_POS);
    step(1'b1, "ext_tie_fill");
    step(1'b1, "ext_tie0");

    // ties
    set_vec(7, 7, 3);
    step(1'b1, "tie_fill");
    step(1'b1, "tie_77_3");
    set_vec(1, 9, 9);
    step(1'b1, "tie_1_99");
    step(1'b1, "tie_1_99b");
    set_vec(0, 0, 0);
    step(1'b1, "zero_fill");
    step(1'b1, "all_zero");

    // back-to-back vectors, one per cycle
    set_vec(9, 1, 1);
    step(1'b1, "b2b_a");
    set_vec(1, 9, 1);
    step(1'b1, "b2b_b");
    set_vec(1, 1, 9);
    step(1'b1, "b2b_c");
    step(1'b1, "b2b_d");
    step(1'b1, "b2b_e");

    // reset mid-stream while output is 2, release with {0,5,0}
    step(1'b0, "mid_reset");
    set_vec(0, 5, 0);
    step(1'b0, "mid_reset_hold");
    step(1'b1, "post_release_capture");
    step(1'b1, "post_release_max1");

    // randomized vectors with occasional reset pulses
    for (int k = 0; k < 400; k++) begin
      set_vec(rand_score(), rand_score(), rand_score());
      step(($urandom_range(0, 19) != 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
